// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage feeding the main/ALU decoder. It holds the PC,
// fetches one word per instruction from a variable-latency instruction
// memory, and presents the held word plus its op/func3/func7 fields. The PC
// advances (pc+4 or pc_target) when the core acknowledges the held word.
//
// Configuration macro: FETCH_ALIGN_CHECK_EN
//   defined   : an acked taken branch to a non word-aligned target raises a
//               sticky fetch error with cause 10 and leaves the PC unchanged
//   undefined : pc_target[1:0] is forced to 00 when loaded
//
// Parameters:
//   RESET_PC        PC loaded on reset
//   TIMEOUT_CYCLES  cycles allowed in REQ+WAIT before a timeout error (>= 2)
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   imem_req        fetch request valid
//   imem_addr       fetch byte address (word aligned)
//   imem_ready      memory accepts the request this cycle
//   imem_rvalid     read data valid
//   imem_rdata      read data
//   instr           held instruction word
//   op/func3/func7  decoder fields sliced from instr
//   instr_pc        PC of the held instruction
//   instr_pc_plus4  instr_pc + 4 (link value)
//   instr_valid     held instruction and fields are valid
//   instr_ack       core retires the held instruction this cycle
//   pc_source       1: next PC = pc_target, 0: next PC = pc + 4
//   pc_target       branch/jump target
//   fetch_error     sticky error flag
//   error_cause     00 none, 01 timeout, 10 misaligned target
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        pc_source,
    input  logic [31:0] pc_target,
    output logic        fetch_error,
    output logic [1:0]  error_cause
);

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          CW       = $clog2(TIMEOUT_CYCLES + 1);
    // Last counter value at which a fetch may still be in flight; reaching
    // it without completing means TIMEOUT_CYCLES cycles were spent.
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_ERROR
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [31:0]   pc;
    logic [CW-1:0] tmo_cnt;
    logic          timed_out;
    logic          align_fault;
    logic [31:0]   target_pc;
    logic [31:0]   next_pc;

`ifdef FETCH_ALIGN_CHECK_EN
    assign align_fault = pc_source && (pc_target[1:0] != 2'b00);
    assign target_pc   = pc_target;
`else
    assign align_fault = 1'b0;
    assign target_pc   = pc_target & ~32'd3;
`endif

    // pc + 4 naturally wraps modulo 2^32 in a 32-bit add.
    assign next_pc   = pc_source ? target_pc : pc + 32'd4;
    assign timed_out = (tmo_cnt == TMO_LAST);

    // ---------------------------------------------------------------- state
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // ----------------------------------------------------------- next state
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  next_state = S_REQ;
            S_REQ: begin
                if (timed_out)       next_state = S_ERROR;
                else if (imem_ready) next_state = S_WAIT;
            end
            S_WAIT: begin
                // Data arriving on the final allowed cycle still completes.
                if (imem_rvalid)    next_state = S_HOLD;
                else if (timed_out) next_state = S_ERROR;
            end
            S_HOLD: begin
                if (instr_ack) next_state = align_fault ? S_ERROR : S_REQ;
            end
            S_ERROR: next_state = S_ERROR;
            default: next_state = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        imem_req    = (state == S_REQ);
        instr_valid = (state == S_HOLD);
        fetch_error = (state == S_ERROR);
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            instr       <= NOP;
            instr_pc    <= RESET_PC;
            tmo_cnt     <= '0;
            error_cause <= 2'b00;
        end else begin
            // Only WAIT accepts read data; stale responses are dropped.
            if (state == S_WAIT && imem_rvalid) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end

            if (state == S_HOLD && instr_ack && !align_fault)
                pc <= next_pc;

            if (next_state == S_REQ && state != S_REQ)
                tmo_cnt <= '0;
            else if (state == S_REQ || state == S_WAIT)
                tmo_cnt <= tmo_cnt + CW'(1);

            // ERROR is only reachable from REQ/WAIT (timeout) or HOLD
            // (misaligned target), so the source state gives the cause.
            if (next_state == S_ERROR && state != S_ERROR)
                error_cause <= (state == S_HOLD) ? 2'b10 : 2'b01;
        end
    end

    assign imem_addr      = pc;
    assign op             = instr[6:0];
    assign func3          = instr[14:12];
    assign func7          = instr[31:25];
    assign instr_pc_plus4 = instr_pc + 32'd4;

endmodule
